instr_fetch_seq: RTL and testbench

- Upstream stage of mipscpu: holds the PC, instruction memory and branch/jump logic that mipscpu lacks.
- Fetches one word per instruction and drives instrword together with a one-cycle newinstr pulse.
- Holds instrword stable for the exact number of cycles the mipscpu control FSM needs for that opcode, then computes the next PC (sequential, beq, j).

---
 rtl/ifu_pkg.sv | 35 +++
 rtl/instr_rom.sv | 44 ++++
 rtl/instr_fetch_seq.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch sequencer that feeds mipscpu:
// the opcode constants it decodes, the halt sentinel word, the sequencer
// state encoding and a small helper used to size the hold counter.
// ----------------------------------------------------------------------------
package ifu_pkg;

    localparam logic [5:0]  OP_RTYPE  = 6'd0;
    localparam logic [5:0]  OP_J      = 6'd2;
    localparam logic [5:0]  OP_BEQ    = 6'd4;
    localparam logic [5:0]  OP_LW     = 6'd35;
    localparam logic [5:0]  OP_SW     = 6'd43;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        EXEC,
        HALT
    } ifu_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/instr_rom.sv
// ----------------------------------------------------------------------------
// instr_rom
// DEPTH x 32 instruction memory with one write port (program load) and one
// synchronous read port. The array itself is never reset, so a program
// survives a sequencer reset; only the registered read data is cleared.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset (clears rdata only)
//   we     - write strobe, waddr/wdata written on the rising edge
//   re     - read enable, rdata <= mem[raddr] on the rising edge
//   rdata  - registered read data, held while re is low
// ----------------------------------------------------------------------------
module instr_rom #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq
// Upstream fetch stage for mipscpu. Holds the PC and instruction memory,
// presents one instruction word at a time with a one-cycle newinstr pulse,
// keeps it stable for as many cycles as mipscpu needs for that opcode and
// then steps the PC (sequential, beq, j).
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   run               - 1 = execute, 0 = stop after the current instruction
//   regs_equal        - datapath compare, sampled on the last beq hold cycle
//   load_en/addr/data - imem write port, honoured only in IDLE/HALT
//   instrword         - current instruction
//   newinstr          - high for the single cycle a new instrword appears
//   pc                - byte address of the current instruction
//   busy, halted      - FETCH/ISSUE/EXEC, HALT
//   retire_count      - only with IFU_RETIRE_CNT_EN: saturating count of
//                       completed instructions (halt word not counted)
// ----------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int unsigned IMEM_DEPTH   = 64,
    parameter int unsigned RTYPE_CYCLES = 4,
    parameter int unsigned MEM_CYCLES   = 5,
    parameter int unsigned BR_CYCLES    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          regs_equal,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    output logic [31:0]                   instrword,
    output logic                          newinstr,
    output logic [31:0]                   pc,
    output logic                          busy,
    output logic                          halted
`ifdef IFU_RETIRE_CNT_EN
    ,
    output logic [31:0]                   retire_count
`endif
);

    import ifu_pkg::*;

    localparam int unsigned AW    = $clog2(IMEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(max3(RTYPE_CYCLES, MEM_CYCLES, BR_CYCLES) + 1);

    ifu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_load;
    logic [31:0]      pc4, br_off, pc_nxt;
    logic [5:0]       opcode;
    logic             exec_last;
    logic             rom_we;

    assign opcode    = instrword[31:26];
    assign exec_last = (state == EXEC) && (cnt == CNT_W'(1));
    assign rom_we    = load_en && ((state == IDLE) || (state == HALT));

    // instrword is the ROM's registered read port, loaded on the FETCH edge,
    // so it becomes valid exactly in ISSUE and holds until the next FETCH.
    instr_rom #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_rom (
        .clock (clock),
        .reset (reset),
        .we    (rom_we),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (state == FETCH),
        .raddr (pc[AW+1:2]),
        .rdata (instrword)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        newinstr  = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                busy      = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                newinstr  = 1'b1;
                state_nxt = (instrword == HALT_WORD) ? HALT : EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_load = CNT_W'(1);
        case (opcode)
            OP_RTYPE:     cnt_load = CNT_W'(RTYPE_CYCLES);
            OP_LW, OP_SW: cnt_load = CNT_W'(MEM_CYCLES);
            OP_BEQ:       cnt_load = CNT_W'(BR_CYCLES);
            default:      cnt_load = CNT_W'(1);
        endcase
    end

    always_comb begin
        pc4    = pc + 32'd4;
        br_off = {{14{instrword[15]}}, instrword[15:0], 2'b00};
        pc_nxt = pc4;
        if (opcode == OP_J) begin
            pc_nxt = {pc4[31:28], instrword[25:0], 2'b00};
        end else if ((opcode == OP_BEQ) && regs_equal) begin
            pc_nxt = pc4 + br_off;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            pc  <= '0;
        end else begin
            if (state == ISSUE) begin
                cnt <= cnt_load;
            end else if (state == EXEC) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (exec_last) begin
                pc <= pc_nxt;
            end
        end
    end

`ifdef IFU_RETIRE_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (exec_last && (retire_count != '1)) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

    localparam logic [31:0] W_ADD  = 32'h0022_1820;
    localparam logic [31:0] W_SUB  = 32'h0022_1822;
    localparam logic [31:0] W_LW   = 32'h8C04_0000;
    localparam logic [31:0] W_HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] W_BEQ3 = 32'h1000_0003;
    localparam logic [31:0] W_J04  = 32'h0800_0004;
    localparam logic [31:0] W_J10  = 32'h0800_0010;
    localparam logic [31:0] W_J3F  = 32'h0800_003F;
    localparam logic [31:0] W_J00  = 32'h0800_0000;

    logic        clock;
    logic        reset;
    logic        run;
    logic        regs_equal;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] instrword;
    logic        newinstr;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
`ifdef IFU_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int checks   = 0;
    int failures = 0;

    instr_fetch_seq #(
        .IMEM_DEPTH   (64),
        .RTYPE_CYCLES (4),
        .MEM_CYCLES   (5),
        .BR_CYCLES    (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .regs_equal   (regs_equal),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .instrword    (instrword),
        .newinstr     (newinstr),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted)
`ifdef IFU_RETIRE_CNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset;
        run        = 1'b0;
        regs_equal = 1'b0;
        load_en    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic load_word(input logic [5:0] a, input logic [31:0] d);
        @(negedge clock);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clock);
        load_en   = 1'b0;
    endtask

    task automatic wait_pulse(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (newinstr === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_halt(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (halted === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        run = 1'b0; regs_equal = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (instrword !== 32'h0) begin failures++; $display("FAIL reset_instrword: got %h exp %h", instrword, 32'h0); end
        checks++; if (pc !== 32'h0)        begin failures++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
        checks++; if (newinstr !== 1'b0)   begin failures++; $display("FAIL reset_newinstr: got %b exp 0", newinstr); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (halted !== 1'b0)     begin failures++; $display("FAIL reset_halted: got %b exp 0", halted); end
`ifdef IFU_RETIRE_CNT_EN
        checks++; if (retire_count !== 32'h0) begin failures++; $display("FAIL reset_retire: got %0d exp 0", retire_count); end
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_sequence;
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] exp_iw [4] = '{W_ADD, W_SUB, W_LW, W_HALT};
        logic [31:0] held;
        bit          exp_p;
        int          k;
        apply_reset();
        load_word(6'd0, W_ADD);
        load_word(6'd1, W_SUB);
        load_word(6'd2, W_LW);
        load_word(6'd3, W_HALT);
        run  = 1'b1;
        k    = 0;
        held = '0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clock);
            exp_p = (cyc == 2) || (cyc == 8) || (cyc == 14) || (cyc == 21);
            checks++;
            if (newinstr !== exp_p) begin
                failures++;
                $display("FAIL seq_pulse cycle %0d: got %b exp %b", cyc, newinstr, exp_p);
            end
            if (exp_p) begin
                checks++; if (pc !== exp_pc[k])        begin failures++; $display("FAIL seq_pc pulse %0d: got %h exp %h", k, pc, exp_pc[k]); end
                checks++; if (instrword !== exp_iw[k]) begin failures++; $display("FAIL seq_instr pulse %0d: got %h exp %h", k, instrword, exp_iw[k]); end
                held = exp_iw[k];
                k++;
            end else if (cyc > 2) begin
                checks++; if (instrword !== held) begin failures++; $display("FAIL seq_stable cycle %0d: got %h exp %h", cyc, instrword, held); end
            end
        end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL seq_halted: got %b exp 1", halted); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL seq_busy_halt: got %b exp 0", busy); end
        checks++; if (pc !== 32'hC)    begin failures++; $display("FAIL seq_pc_halt: got %h exp %h", pc, 32'hC); end
        run = 1'b0;
    endtask

    task automatic run_beq(input logic first, input logic last, input logic [31:0] exp_target);
        bit got;
        apply_reset();
        run = 1'b1;
        wait_pulse(got);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL beq_pulse0 timeout: got %b exp 1", got); end
        wait_pulse(got);
        checks++; if (got !== 1'b1)          begin failures++; $display("FAIL beq_pulse1 timeout: got %b exp 1", got); end
        checks++; if (pc !== 32'h10)         begin failures++; $display("FAIL beq_pc: got %h exp %h", pc, 32'h10); end
        checks++; if (instrword !== W_BEQ3)  begin failures++; $display("FAIL beq_instr: got %h exp %h", instrword, W_BEQ3); end
        regs_equal = first;
        @(negedge clock);
        @(negedge clock);
        regs_equal = last;
        wait_halt(got);
        regs_equal = 1'b0;
        checks++; if (got !== 1'b1)          begin failures++; $display("FAIL beq_halt timeout: got %b exp 1", got); end
        checks++; if (pc !== exp_target)     begin failures++; $display("FAIL beq_target eq=%b: got %h exp %h", last, pc, exp_target); end
        checks++; if (instrword !== W_HALT)  begin failures++; $display("FAIL beq_halt_word: got %h exp %h", instrword, W_HALT); end
        run = 1'b0;
    endtask

    task automatic test_beq;
        apply_reset();
        load_word(6'd0, W_J04);
        load_word(6'd4, W_BEQ3);
        load_word(6'd5, W_HALT);
        load_word(6'd8, W_HALT);
        run_beq(1'b0, 1'b1, 32'h20);
        run_beq(1'b1, 1'b0, 32'h14);
    endtask

    task automatic test_jump;
        logic [31:0] exp_pc [4] = '{32'h40, 32'hFC, 32'h100, 32'h0};
        logic [31:0] exp_iw [4] = '{W_J3F, 32'h0, W_J00, W_J00};
        bit got;
        apply_reset();
        load_word(6'd0, W_J10);
        load_word(6'd16, W_J10);
        run = 1'b1;
        wait_pulse(got);
        checks++; if (got !== 1'b1 || pc !== 32'h0 || instrword !== W_J10) begin failures++; $display("FAIL jmp_first: got pc %h iw %h exp pc %h iw %h", pc, instrword, 32'h0, W_J10); end
        wait_pulse(got);
        checks++; if (got !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL jmp_to40: got %h exp %h", pc, 32'h40); end
        wait_pulse(got);
        checks++; if (got !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL jmp_self: got %h exp %h", pc, 32'h40); end
        run = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL jmp_idle_busy: got %b exp 0", busy); end
        checks++; if (pc !== 32'h40)  begin failures++; $display("FAIL jmp_idle_pc: got %h exp %h", pc, 32'h40); end
        load_word(6'd16, W_J3F);
        load_word(6'd0, W_J00);
        load_word(6'd63, 32'h0);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(got);
            checks++; if (got !== 1'b1)           begin failures++; $display("FAIL jmp_chain%0d timeout: got %b exp 1", i, got); end
            checks++; if (pc !== exp_pc[i])       begin failures++; $display("FAIL jmp_chain%0d pc: got %h exp %h", i, pc, exp_pc[i]); end
            checks++; if (instrword !== exp_iw[i]) begin failures++; $display("FAIL jmp_chain%0d instr: got %h exp %h", i, instrword, exp_iw[i]); end
        end
        run = 1'b0;
        repeat (4) @(negedge clock);
        checks++; if (busy !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL jmp_stop: got busy %b pc %h exp busy 0 pc %h", busy, pc, 32'h0); end
    endtask

    task automatic test_run_drop;
        bit got;
        int pulses;
        apply_reset();
        load_word(6'd0, W_LW);
        load_word(6'd1, W_HALT);
        run = 1'b1;
        wait_pulse(got);
        checks++; if (got !== 1'b1 || instrword !== W_LW) begin failures++; $display("FAIL drop_lw: got %h exp %h", instrword, W_LW); end
        @(negedge clock);
        run       = 1'b0;
        load_en   = 1'b1;
        load_addr = 6'd1;
        load_data = 32'h1234_5678;
        @(negedge clock);
        load_en   = 1'b0;
        pulses    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (newinstr === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0)    begin failures++; $display("FAIL drop_no_pulse: got %0d exp 0", pulses); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL drop_busy: got %b exp 0", busy); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL drop_halted: got %b exp 0", halted); end
        checks++; if (pc !== 32'h4)    begin failures++; $display("FAIL drop_pc: got %h exp %h", pc, 32'h4); end
        run = 1'b1;
        wait_pulse(got);
        checks++; if (got !== 1'b1 || pc !== 32'h4) begin failures++; $display("FAIL drop_resume_pc: got %h exp %h", pc, 32'h4); end
        checks++; if (instrword !== W_HALT)        begin failures++; $display("FAIL drop_ignored_load: got %h exp %h", instrword, W_HALT); end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_exec;
        bit got;
        apply_reset();
        load_word(6'd0, W_ADD);
        load_word(6'd1, W_SUB);
        load_word(6'd2, W_LW);
        load_word(6'd3, W_HALT);
        run = 1'b1;
        wait_pulse(got);
        wait_pulse(got);
        checks++; if (got !== 1'b1 || pc !== 32'h4) begin failures++; $display("FAIL rst_pre_pc: got %h exp %h", pc, 32'h4); end
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (instrword !== 32'h0) begin failures++; $display("FAIL rst_mid_instr: got %h exp %h", instrword, 32'h0); end
        checks++; if (pc !== 32'h0)        begin failures++; $display("FAIL rst_mid_pc: got %h exp %h", pc, 32'h0); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
        @(negedge clock);
        reset = 1'b1;
        wait_pulse(got);
        checks++; if (got !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL rst_restart_pc: got %h exp %h", pc, 32'h0); end
        checks++; if (instrword !== W_ADD)          begin failures++; $display("FAIL rst_imem_kept: got %h exp %h", instrword, W_ADD); end
        run = 1'b0;
    endtask

`ifdef IFU_RETIRE_CNT_EN
    task automatic test_retire;
        bit got;
        apply_reset();
        checks++; if (retire_count !== 32'h0) begin failures++; $display("FAIL ret_reset: got %0d exp 0", retire_count); end
        run = 1'b1;
        wait_halt(got);
        checks++; if (got !== 1'b1 || retire_count !== 32'd3) begin failures++; $display("FAIL ret_count: got %0d exp 3", retire_count); end
        repeat (6) @(negedge clock);
        checks++; if (retire_count !== 32'd3) begin failures++; $display("FAIL ret_frozen: got %0d exp 3", retire_count); end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_beq();
        test_jump();
        test_run_drop();
        test_reset_mid_exec();
`ifdef IFU_RETIRE_CNT_EN
        test_retire();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
